// File: rtl/sprite_blitter.sv
// Sprite draw engine: walks a sprite in a 1-cycle-latency ROM and writes opaque, on-screen pixels to the frame buffer.
// Define SPRITE_MIRROR_EN to add the mirror_x port, which draws the sprite horizontally flipped.
module sprite_blitter #(
    parameter int ADDR_WIDTH      = 12,
    parameter int SPRITE_W        = 16,
    parameter int SPRITE_H        = 16,
    parameter int SCREEN_W        = 320,
    parameter int SCREEN_H        = 240,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] sprite_base,
    input  logic [9:0]            pos_x,
    input  logic [8:0]            pos_y,
`ifdef SPRITE_MIRROR_EN
    input  logic                  mirror_x,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [3:0]            rom_data,
    output logic                  fb_we,
    output logic [9:0]            fb_x,
    output logic [8:0]            fb_y,
    output logic [3:0]            fb_data
);
    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  fetch;
    logic                  last_addr;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [9:0]            x_q;
    logic [8:0]            y_q;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col_term;
    logic                  pipe_valid;
    logic [COL_W-1:0]      pipe_col;
    logic [ROW_W-1:0]      pipe_row;
    logic [10:0]           x_sum;
    logic [9:0]            y_sum;

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each always_comb assigns defaults first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: if (last_addr) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b1;
        done   = 1'b0;
        fetch  = 1'b0;
        accept = 1'b0;
        case (state)
            S_IDLE: begin
                busy   = 1'b0;
                accept = start;
            end
            S_FETCH: fetch = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    assign last_addr = (col == COL_LAST) && (row == ROW_LAST);

    // Pipeline stage lines up the issued coordinate with the ROM's registered data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            col        <= '0;
            row        <= '0;
            pipe_valid <= 1'b0;
            pipe_col   <= '0;
            pipe_row   <= '0;
        end else begin
            pipe_valid <= fetch;
            if (fetch) begin
                pipe_col <= col;
                pipe_row <= row;
            end
            if (accept) begin
                base_q <= sprite_base;
                x_q    <= pos_x;
                y_q    <= pos_y;
                col    <= '0;
                row    <= '0;
            end else if (fetch) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mirror_q <= 1'b0;
        end else if (accept) begin
            mirror_q <= mirror_x;
        end
    end

    // Only the ROM column is flipped; screen placement still uses col.
    assign col_term = mirror_q ? (COL_LAST - col) : col;
`else
    assign col_term = col;
`endif

    assign rom_addr = fetch ? (base_q + ADDR_WIDTH'(row) * ADDR_WIDTH'(SPRITE_W) + ADDR_WIDTH'(col_term))
                            : '0;

    // Sums are one bit wider than the position so off-screen pixels cannot wrap back on.
    assign x_sum   = {1'b0, x_q} + 11'(pipe_col);
    assign y_sum   = {1'b0, y_q} + 10'(pipe_row);
    assign fb_we   = pipe_valid && (rom_data != 4'(TRANSPARENT_IDX))
                     && (x_sum < 11'(SCREEN_W)) && (y_sum < 10'(SCREEN_H));
    assign fb_x    = fb_we ? x_sum[9:0] : '0;
    assign fb_y    = fb_we ? y_sum[8:0] : '0;
    assign fb_data = fb_we ? rom_data : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: cycle-indexed reference model plus directed literal checks.
// Mirror checks are compiled in when SPRITE_MIRROR_EN is defined.
module tb_sprite_blitter;
    localparam int N = 256;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [11:0] sprite_base;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        busy;
    logic        done;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [9:0]  fb_x;
    logic [8:0]  fb_y;
    logic [3:0]  fb_data;
`ifdef SPRITE_MIRROR_EN
    logic        mirror_x;
`endif

    logic [3:0] rom [0:4095];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: mt is the cycle index since the accepting edge, 0 when idle.
    int mt = 0;
    int m_base;
    int m_x;
    int m_y;
    bit m_mirror = 1'b0;

    int write_cnt;
    int done_cnt;
    int max_x;
    int max_y;
    int row_hits;
    int bad_cnt;
    int hit_row = -1;

    sprite_blitter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .sprite_base (sprite_base),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
`ifdef SPRITE_MIRROR_EN
        .mirror_x    (mirror_x),
`endif
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_data     (fb_data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int addr_of(input int k);
        int c;
        c = m_mirror ? (15 - (k % 16)) : (k % 16);
        return (m_base + (k / 16) * 16 + c) % 4096;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            mt = 0;
        end else if (mt == 0) begin
            if (start) begin
                mt     = 1;
                m_base = int'(sprite_base);
                m_x    = int'(pos_x);
                m_y    = int'(pos_y);
`ifdef SPRITE_MIRROR_EN
                m_mirror = mirror_x;
`endif
            end
        end else if (mt == N + 2) begin
            mt = 0;
        end else begin
            mt++;
        end
    end

    always @(negedge Clk) begin
        int e_addr, e_we, e_x, e_y, e_d, k, sx, sy, d;
        if (chk_en) begin
            e_addr = 0; e_we = 0; e_x = 0; e_y = 0; e_d = 0;
            if (mt >= 1 && mt <= N) e_addr = addr_of(mt - 1);
            if (mt >= 2 && mt <= N + 1) begin
                k  = mt - 2;
                d  = int'(rom[addr_of(k)]);
                sx = m_x + k % 16;
                sy = m_y + k / 16;
                if (d != 0 && sx < 320 && sy < 240) begin
                    e_we = 1; e_x = sx; e_y = sy; e_d = d;
                end
            end
            check("busy", busy, (mt >= 1) ? 1 : 0);
            check("done", done, (mt == N + 2) ? 1 : 0);
            check("rom_addr", rom_addr, e_addr);
            check("fb_we", fb_we, e_we);
            check("fb_x", fb_x, e_x);
            check("fb_y", fb_y, e_y);
            check("fb_data", fb_data, e_d);
            if (fb_we === 1'b1) begin
                write_cnt++;
                if (int'(fb_x) > max_x) max_x = int'(fb_x);
                if (int'(fb_y) > max_y) max_y = int'(fb_y);
                if (fb_x >= 10'd320 || fb_y >= 9'd240) bad_cnt++;
                if (int'(fb_y) == hit_row) row_hits++;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clear_stats();
        write_cnt = 0; done_cnt = 0; max_x = 0; max_y = 0;
        row_hits = 0; bad_cnt = 0; hit_row = -1;
    endtask

    // Pulses start for one cycle; returns in cycle 1 of the draw.
    task automatic launch(input int base, input int x, input int y);
        sprite_base = 12'(base);
        pos_x = 10'(x);
        pos_y = 9'(y);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 4'((i % 15) + 1);
        Reset = 1'b1; start = 1'b0; sprite_base = '0; pos_x = '0; pos_y = '0;
`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b0;
`endif
        clear_stats();
        tick(3);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_fb_xyd", {fb_x, fb_y, fb_data}, 0);
        Reset = 1'b0;
        tick(1);

        // Basic draw
        clear_stats();
        launch(0, 10, 20);
        check("basic_c1_addr", rom_addr, 0);
        check("basic_c1_busy", busy, 1);
        tick(1);
        check("basic_first_we", fb_we, 1);
        check("basic_first_xy", {fb_x, fb_y}, {10'd10, 9'd20});
        check("basic_first_data", fb_data, 1);
        tick(255);
        check("basic_last_we", fb_we, 1);
        check("basic_last_xy", {fb_x, fb_y}, {10'd25, 9'd35});
        check("basic_last_data", fb_data, 1);
        check("basic_c257_done", done, 0);
        tick(1);
        check("basic_c258_done", done, 1);
        tick(1);
        check("basic_c259_busy", busy, 0);
        check("basic_writes", write_cnt, 256);
        check("basic_done_cnt", done_cnt, 1);

        // Transparency: row 3 of the sprite at 0x100 is all zero
        for (int i = 0; i < 16; i++) rom[12'h130 + i] = 4'h0;
        clear_stats();
        hit_row = 23;
        launch(12'h100, 10, 20);
        tick(1);
        check("transp_first_data", fb_data, 2);
        tick(255);
        check("transp_c257_done", done, 0);
        tick(1);
        check("transp_c258_done", done, 1);
        tick(1);
        check("transp_writes", write_cnt, 240);
        check("transp_row3_hits", row_hits, 0);
        for (int i = 0; i < 16; i++) rom[12'h130 + i] = 4'(((12'h130 + i) % 15) + 1);

        // Clipping at the bottom-right corner
        clear_stats();
        launch(0, 310, 232);
        tick(257);
        check("clip_c258_done", done, 1);
        tick(1);
        check("clip_writes", write_cnt, 80);
        check("clip_max_x", max_x, 319);
        check("clip_max_y", max_y, 239);
        check("clip_offscreen", bad_cnt, 0);

        // Start held high for 300 cycles
        clear_stats();
        sprite_base = '0; pos_x = 10'd10; pos_y = 9'd20; start = 1'b1;
        tick(1);
        tick(257);
        check("held_c258_done", done, 1);
        check("held_writes_before_done", write_cnt, 256);
        tick(1);
        check("held_c259_busy", busy, 0);
        tick(1);
        check("held_c260_busy", busy, 1);
        check("held_c260_addr", rom_addr, 0);
        tick(40);
        start = 1'b0;
        tick(218);
        check("held_end_busy", busy, 0);
        check("held_done_cnt", done_cnt, 2);

        // Start pulse in the first idle cycle after done
        clear_stats();
        launch(0, 10, 20);
        tick(258);
        check("b2b_idle_busy", busy, 0);
        launch(12'h200, 40, 50);
        check("b2b_new_addr", rom_addr, 12'h200);
        check("b2b_new_busy", busy, 1);
        tick(258);
        check("b2b_writes", write_cnt, 512);

        // Reset in cycle 50
        clear_stats();
        launch(0, 10, 20);
        tick(49);
        Reset = 1'b1;
        tick(1);
        check("rstmid_fb_we", fb_we, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_addr", rom_addr, 0);
        Reset = 1'b0;
        tick(300);
        check("rstmid_done_cnt", done_cnt, 0);
        check("rstmid_writes", write_cnt, 49);
        clear_stats();
        launch(0, 10, 20);
        tick(258);
        check("after_rst_writes", write_cnt, 256);
        check("after_rst_done_cnt", done_cnt, 1);

        // Reset wins over start in the same cycle
        Reset = 1'b1; start = 1'b1;
        tick(1);
        Reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 0);
        tick(1);
        check("rst_prio_busy2", busy, 0);

`ifdef SPRITE_MIRROR_EN
        rom[0] = 4'h5;
        rom[15] = 4'hC;
        mirror_x = 1'b1;
        clear_stats();
        launch(0, 0, 0);
        mirror_x = 1'b0;
        tick(1);
        check("mirror_first_xy", {fb_x, fb_y}, 0);
        check("mirror_first_data", fb_data, 12);
        tick(15);
        check("mirror_c17_xy", {fb_x, fb_y}, {10'd15, 9'd0});
        check("mirror_c17_data", fb_data, 5);
        tick(242);
        check("mirror_writes", write_cnt, 256);
        rom[0] = 4'h1;
        rom[15] = 4'h1;
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
